// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - borrow_in, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_diff;
   logic             r_br;
   logic             r_borrow_out;
   logic [CW-1:0]    r_cnt;

   logic             w_accept;
   logic             w_last;
   logic             w_ai;
   logic             w_bi;
   logic             w_d;
   logic             w_br_next;
   logic [WIDTH-1:0] w_res_next;

   assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_last    = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));
   assign w_ai      = r_a[0];
   assign w_bi      = r_b[0];
   assign w_d       = w_ai ^ w_bi ^ r_br;
   assign w_br_next = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);

   // Each difference bit enters at the MSB so the first bit ends up at the LSB.
   generate
      if (WIDTH == 1) begin : g_res_w1
         assign w_res_next = w_d;
      end else begin : g_res_wn
         assign w_res_next = {w_d, r_res[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_next = S_RUN;
         S_RUN:   if (w_last) w_state_next = S_DONE;
         S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         S_RUN:   busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a          <= '0;
         r_b          <= '0;
         r_res        <= '0;
         r_br         <= 1'b0;
         r_cnt        <= '0;
         r_diff       <= '0;
         r_borrow_out <= 1'b0;
      end else if (w_accept) begin
         r_a   <= a;
         r_b   <= b;
         r_res <= '0;
         r_br  <= borrow_in;
         r_cnt <= '0;
      end else if (r_state == S_RUN) begin
         r_a   <= r_a >> 1;
         r_b   <= r_b >> 1;
         r_res <= w_res_next;
         r_br  <= w_br_next;
         r_cnt <= r_cnt + CW'(1);
         if (w_last) begin
            r_diff       <= w_res_next;
            r_borrow_out <= w_br_next;
         end
      end
   end

   assign diff       = r_diff;
   assign borrow_out = r_borrow_out;

`ifdef SERIAL_SUB_OVF_EN
   logic r_a_msb;
   logic r_b_msb;
   logic r_ovf;

   // Operand MSBs are captured at start because the shift registers lose them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         r_a_msb <= a[WIDTH-1];
         r_b_msb <= b[WIDTH-1];
      end else if (w_last) begin
         r_ovf <= (r_a_msb != r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);
      end
   end

   assign ovf = r_ovf;
`endif

endmodule
